// File: rtl/spi_slave_reg_ctrl_if.sv
// Signal bundle between the SPI command sequencer and its pins, register file and memory-read bridge.
interface spi_slave_reg_ctrl_if;
  logic        cs_n;
  logic        sdi;
  logic        sdo;
  logic        sdo_oe;
  logic [1:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic        reg_wr_valid;
  logic [1:0]  reg_rd_addr;
  logic [7:0]  reg_rd_data;
  logic [7:0]  dummy_cycles;
  logic [15:0] wrap_length;
  logic        mem_rd_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        underrun;

  modport slave (
    input  cs_n, sdi, reg_rd_data, dummy_cycles, wrap_length, mem_rd_data, mem_rd_valid,
    output sdo, sdo_oe, reg_wr_addr, reg_wr_data, reg_wr_valid, reg_rd_addr,
           mem_rd_req, mem_addr, underrun
  );

  modport master (
    output cs_n, sdi, reg_rd_data, dummy_cycles, wrap_length, mem_rd_data, mem_rd_valid,
    input  sdo, sdo_oe, reg_wr_addr, reg_wr_data, reg_wr_valid, reg_rd_addr,
           mem_rd_req, mem_addr, underrun
  );
endinterface

// File: rtl/spi_slave_reg_ctrl.sv
// SPI slave command sequencer: register write/read commands and the 0x0B streamed memory read
// with a configurable dummy phase and address wrap window.
module spi_slave_reg_ctrl (
  input  logic sclk,
  input  logic rst,
  spi_slave_reg_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    CMD, REG_WDATA, REG_TURN, REG_RDATA, ADDR, DUMMY, MEM_DATA, IGNORE
  } state_t;

  state_t      state_reg;
  logic [4:0]  bit_cnt_reg;
  logic [31:0] rx_reg;
  logic [31:0] tx_reg;
  logic [1:0]  wr_idx_reg;
  logic [31:0] start_addr_reg;
  logic [15:0] word_cnt_reg;
  logic [7:0]  dummy_cnt_reg;
  logic [31:0] hold_data_reg;
  logic        hold_valid_reg;
  logic        sdo_reg;
  logic        sdo_oe_reg;
  logic        reg_wr_valid_reg;
  logic [1:0]  reg_wr_addr_reg;
  logic [7:0]  reg_wr_data_reg;
  logic [1:0]  reg_rd_addr_reg;
  logic        mem_rd_req_reg;
  logic [31:0] mem_addr_reg;
  logic        underrun_reg;

  logic [31:0] rx_next;
  logic [7:0]  cmd;
  logic        load_edge;
  logic        load_valid;
  logic [31:0] load_word;
  logic        wrap_hit;

  assign rx_next   = {rx_reg[30:0], bus.sdi};
  assign cmd       = rx_next[7:0];
  assign load_edge = (state_reg == MEM_DATA) && (bit_cnt_reg == 5'd0);
  // Data arriving on the load edge itself is still in time for that word.
  assign load_valid = hold_valid_reg | bus.mem_rd_valid;
  assign load_word  = bus.mem_rd_valid ? bus.mem_rd_data :
                      (hold_valid_reg ? hold_data_reg : 32'h0);
  assign wrap_hit   = (bus.wrap_length != 16'h0) && ((word_cnt_reg + 16'd1) == bus.wrap_length);

  always_ff @(posedge sclk) begin
    reg_wr_valid_reg <= 1'b0;
    mem_rd_req_reg   <= 1'b0;
    underrun_reg     <= 1'b0;
    if (rst) begin
      state_reg       <= CMD;
      bit_cnt_reg     <= 5'd0;
      rx_reg          <= 32'h0;
      tx_reg          <= 32'h0;
      wr_idx_reg      <= 2'd0;
      start_addr_reg  <= 32'h0;
      word_cnt_reg    <= 16'h0;
      dummy_cnt_reg   <= 8'h0;
      hold_data_reg   <= 32'h0;
      hold_valid_reg  <= 1'b0;
      sdo_reg         <= 1'b0;
      sdo_oe_reg      <= 1'b0;
      reg_wr_addr_reg <= 2'd0;
      reg_wr_data_reg <= 8'h0;
      reg_rd_addr_reg <= 2'd0;
      mem_addr_reg    <= 32'h0;
    end else if (bus.cs_n) begin
      state_reg      <= CMD;
      bit_cnt_reg    <= 5'd0;
      sdo_reg        <= 1'b0;
      sdo_oe_reg     <= 1'b0;
      hold_valid_reg <= 1'b0;
    end else begin
      if (bus.mem_rd_valid) begin
        hold_data_reg  <= bus.mem_rd_data;
        hold_valid_reg <= 1'b1;
      end
      case (state_reg)
        CMD: begin
          rx_reg      <= rx_next;
          bit_cnt_reg <= bit_cnt_reg + 5'd1;
          if (bit_cnt_reg == 5'd7) begin
            bit_cnt_reg <= 5'd0;
            if (cmd[7:6] == 2'b00 && cmd[3:0] == 4'h1) begin
              wr_idx_reg <= cmd[5:4];
              state_reg  <= REG_WDATA;
            end else if (cmd[7:6] == 2'b00 && cmd[3:0] == 4'h5) begin
              reg_rd_addr_reg <= cmd[5:4];
              state_reg       <= REG_TURN;
            end else if (cmd == 8'h0B) begin
              state_reg <= ADDR;
            end else begin
              state_reg <= IGNORE;
            end
          end
        end
        REG_WDATA: begin
          rx_reg      <= rx_next;
          bit_cnt_reg <= bit_cnt_reg + 5'd1;
          if (bit_cnt_reg == 5'd7) begin
            reg_wr_valid_reg <= 1'b1;
            reg_wr_addr_reg  <= wr_idx_reg;
            reg_wr_data_reg  <= cmd;
            state_reg        <= IGNORE;
          end
        end
        REG_TURN: begin
          sdo_reg     <= bus.reg_rd_data[7];
          tx_reg      <= {bus.reg_rd_data[6:0], 25'h0};
          sdo_oe_reg  <= 1'b1;
          bit_cnt_reg <= 5'd0;
          state_reg   <= REG_RDATA;
        end
        REG_RDATA: begin
          if (bit_cnt_reg == 5'd7) begin
            sdo_reg    <= 1'b0;
            sdo_oe_reg <= 1'b0;
            state_reg  <= IGNORE;
          end else begin
            sdo_reg     <= tx_reg[31];
            tx_reg      <= {tx_reg[30:0], 1'b0};
            bit_cnt_reg <= bit_cnt_reg + 5'd1;
          end
        end
        ADDR: begin
          rx_reg      <= rx_next;
          bit_cnt_reg <= bit_cnt_reg + 5'd1;
          if (bit_cnt_reg == 5'd31) begin
            start_addr_reg <= rx_next;
            mem_addr_reg   <= rx_next;
            mem_rd_req_reg <= 1'b1;
            word_cnt_reg   <= 16'h0;
            dummy_cnt_reg  <= bus.dummy_cycles;
            state_reg      <= (bus.dummy_cycles == 8'h0) ? MEM_DATA : DUMMY;
          end
        end
        DUMMY: begin
          dummy_cnt_reg <= dummy_cnt_reg - 8'd1;
          if (dummy_cnt_reg == 8'd1)
            state_reg <= MEM_DATA;
        end
        MEM_DATA: begin
          // Five-bit counter wraps 31 -> 0, so every 32nd edge is a load edge.
          bit_cnt_reg <= bit_cnt_reg + 5'd1;
          if (load_edge) begin
            sdo_reg        <= load_word[31];
            tx_reg         <= {load_word[30:0], 1'b0};
            sdo_oe_reg     <= 1'b1;
            underrun_reg   <= ~load_valid;
            hold_valid_reg <= 1'b0;
            mem_rd_req_reg <= 1'b1;
            if (wrap_hit) begin
              mem_addr_reg <= start_addr_reg;
              word_cnt_reg <= 16'h0;
            end else begin
              mem_addr_reg <= mem_addr_reg + 32'd4;
              word_cnt_reg <= word_cnt_reg + 16'd1;
            end
          end else begin
            sdo_reg <= tx_reg[31];
            tx_reg  <= {tx_reg[30:0], 1'b0};
          end
        end
        IGNORE: begin
          sdo_reg    <= 1'b0;
          sdo_oe_reg <= 1'b0;
        end
        default: state_reg <= CMD;
      endcase
    end
  end

  assign bus.sdo          = sdo_reg;
  assign bus.sdo_oe       = sdo_oe_reg;
  assign bus.reg_wr_valid = reg_wr_valid_reg;
  assign bus.reg_wr_addr  = reg_wr_addr_reg;
  assign bus.reg_wr_data  = reg_wr_data_reg;
  assign bus.reg_rd_addr  = reg_rd_addr_reg;
  assign bus.mem_rd_req   = mem_rd_req_reg;
  assign bus.mem_addr     = mem_addr_reg;
  assign bus.underrun     = underrun_reg;
endmodule

// File: doc/spi_slave_reg_ctrl.md
# spi_slave_reg_ctrl

Single-lane SPI slave command sequencer clocked by `sclk`. It deserialises the command byte from `sdi` and performs register writes and reads against the 4x8 SPI configuration register file. It also sequences the memory read command: 32-bit address, then a dummy phase whose length and wrap behaviour come from that register file, then streamed 32-bit read words. It sits between the pad-level SPI pins and the register file / memory-read bridge.

## Interface
- No parameters; all widths fixed.
- `sclk` in 1 — SPI clock; all logic on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `cs_n` in 1 — chip select, active low, sampled on `sclk`.
- `sdi` in 1 — serial data in, MSB first.
- `sdo` out 1 — serial data out, MSB first.
- `sdo_oe` out 1 — output enable for `sdo`.
- `reg_wr_addr` out 2 — register write index.
- `reg_wr_data` out 8 — register write data.
- `reg_wr_valid` out 1 — one-cycle register write strobe.
- `reg_rd_addr` out 2 — register read index.
- `reg_rd_data` in 8 — register read data, combinational from `reg_rd_addr`.
- `dummy_cycles` in 8 — dummy phase length, in cycles.
- `wrap_length` in 16 — words per wrap window; 0 means no wrap.
- `mem_rd_req` out 1 — one-cycle read request strobe.
- `mem_addr` out 32 — read address, valid with `mem_rd_req`.
- `mem_rd_data` in 32 — read data.
- `mem_rd_valid` in 1 — read data valid, one cycle.
- `underrun` out 1 — one-cycle pulse when a word is loaded without returned data.

## Operation
- States: CMD, REG_WDATA, REG_TURN, REG_RDATA, ADDR, DUMMY, MEM_DATA, IGNORE.
- `cs_n` high at any edge forces CMD and clears the bit counter. `sdo_oe` is 0 and pending strobes are dropped; an already-issued `mem_rd_req` is not recalled. Same effect as `rst` on the FSM.
- CMD: shift 8 bits. Decode on the 8th bit:
  - `0x01`/`0x11`/`0x21`/`0x31`: write register N = cmd[5:4]. Go to REG_WDATA.
  - `0x05`/`0x15`/`0x25`/`0x35`: read register N. Latch `reg_rd_addr`=N, go to REG_TURN.
  - `0x0B`: memory read. Go to ADDR.
  - Any other value: go to IGNORE.
- REG_WDATA: shift 8 bits. After the 8th bit, pulse `reg_wr_valid` with addr/data, then go to IGNORE.
- REG_TURN: one cycle with `sdo_oe`=0. Capture `reg_rd_data` into the tx shifter. Go to REG_RDATA.
- REG_RDATA: drive 8 bits with `sdo_oe`=1, then go to IGNORE.
- ADDR: shift 32 bits into the start address; the word counter is set to 0. After the 32nd bit:
  - Pulse `mem_rd_req` with `mem_addr` = start address.
  - Latch `dummy_cycles` into an 8-bit down-counter D.
  - Go to DUMMY, or directly to the load edge if D = 0.
- DUMMY: count D cycles, `sdo_oe`=0.
- MEM_DATA, at each load edge:
  - Load the 32-bit tx word from the data holding register, which captures `mem_rd_data` on any `mem_rd_valid`. Clear the holding-valid flag.
  - If no valid was captured, load 0 and pulse `underrun`.
  - In the same cycle, compute the next address and pulse `mem_rd_req` with it (prefetch).
  - Drive 32 bits with `sdo_oe`=1; the next load edge follows the 32nd bit. Continues until `cs_n` rises.
- Next address rule:
  - Word counter increments per loaded word.
  - If `wrap_length` ≠ 0 and counter+1 == `wrap_length`: next address = start address, counter = 0.
  - Otherwise: next address = previous + 4, modulo 2^32.
  - `wrap_length` is sampled live at each load.
- IGNORE: `sdo_oe`=0, `sdi` ignored, no strobes.
- `rst` has priority over `cs_n`.

## Timing
- Edges are numbered from 1, starting with the first `sclk` rise at which `cs_n`=0; E1..E8 sample the command bits.
- Register write:
  - E9..E16 sample the data bits.
  - `reg_wr_valid`=1 in the cycle after E16 only.
- Register read:
  - `reg_rd_addr` updates after E8.
  - Tx load at E9.
  - `sdo` = bit7 after E9 … bit0 after E16; `sdo_oe`=1 after E9 through E16 only.
- Memory read:
  - Address bits at E9..E40.
  - `mem_rd_req` after E40.
  - Dummy edges E41..E40+D.
  - First load edge L = E41+D; `sdo` bit31 after L.
  - Word n loads at L+32n. Each load issues the request for the following word, giving the memory 32 cycles to respond; the first word gets D+1 cycles.
- `mem_rd_valid` is sampled at the load edge itself.
- Reset values (all outputs): `sdo`=0, `sdo_oe`=0, `reg_wr_valid`=0, `reg_wr_addr`=0, `reg_wr_data`=0, `reg_rd_addr`=0, `mem_rd_req`=0, `mem_addr`=0, `underrun`=0. State is CMD.

## Test plan
- Register write: `0x11`,`0x08` → single `reg_wr_valid` after E16 with addr=1, data=0x08; no other strobe.
- Register read: `0x25` with `reg_rd_data`=0xA5 → `reg_rd_addr`=2 after E8; `sdo` = 1,0,1,0,0,1,0,1 after E9..E16; `sdo_oe` low after E17.
- Memory read: `0x0B`, addr 0x1000, D=32, memory returning 5 cycles after each request with 0xDEADBEEF / 0x12345678:
  - `mem_rd_req` after E40 with addr 0x1000, and after E73 with 0x1004.
  - `sdo` streams 0xDEADBEEF from E73 onward, then 0x12345678 after E105.
- Wrap: `wrap_length`=2, start 0x2000 → request address sequence 0x2000, 0x2004, 0x2000, 0x2004; no wrap at 0xFFFFFFFC with `wrap_length`=0 → next address 0x0.
- Underrun and D=0: `dummy_cycles`=0, memory never responds → load at E41, `underrun` pulse, `sdo` all zeros for 32 bits.
- Abort: `cs_n` rises mid-write after 4 data bits → no `reg_wr_valid`. The next transaction `0x01`,`0xFF` writes reg0 correctly. Invalid cmd `0x99` → no strobes, `sdo_oe`=0 throughout.
